// File: rtl/controle_pkg.sv
// Opcode map, ctrl bundle layout, FSM states and the opcode -> ctrl decode shared by
// unidade_controle_multiciclo and its submodules.
package controle_pkg;

    localparam logic [31:0] OP_ADD       = 32'd0;
    localparam logic [31:0] OP_SUB       = 32'd1;
    localparam logic [31:0] OP_MUL       = 32'd2;
    localparam logic [31:0] OP_DIV       = 32'd3;
    localparam logic [31:0] OP_AND       = 32'd4;
    localparam logic [31:0] OP_OR        = 32'd5;
    localparam logic [31:0] OP_XOR       = 32'd6;
    localparam logic [31:0] OP_NOT       = 32'd7;
    localparam logic [31:0] OP_SLT       = 32'd8;
    localparam logic [31:0] OP_SLL       = 32'd9;
    localparam logic [31:0] OP_SRL       = 32'd10;
    localparam logic [31:0] OP_ADDI      = 32'd11;
    localparam logic [31:0] OP_SUBI      = 32'd12;
    localparam logic [31:0] OP_LI        = 32'd13;
    localparam logic [31:0] OP_LW        = 32'd14;
    localparam logic [31:0] OP_SW        = 32'd15;
    localparam logic [31:0] OP_BEQ       = 32'd16;
    localparam logic [31:0] OP_BNE       = 32'd17;
    localparam logic [31:0] OP_J         = 32'd18;
    localparam logic [31:0] OP_JR        = 32'd19;
    localparam logic [31:0] OP_JAL       = 32'd20;
    localparam logic [31:0] OP_IN        = 32'd21;
    localparam logic [31:0] OP_OUT       = 32'd22;
    localparam logic [31:0] OP_PREEMPON  = 32'd23;
    localparam logic [31:0] OP_HLT       = 32'd24;
    localparam logic [31:0] OP_FINALIZE  = 32'd25;
    localparam logic [31:0] OP_NOP       = 32'd26;
    localparam logic [31:0] OP_PREEMPOFF = 32'd27;
    localparam logic [31:0] OP_HDTOREG   = 32'd28;
    localparam logic [31:0] OP_HDTOINST  = 32'd29;
    localparam logic [31:0] OP_MOV       = 32'd30;
    localparam logic [31:0] OP_REGTOHD   = 32'd31;

    // ctrl layout: alu_op[3:0], io[5:4], write_src[7:6], then single-bit flags
    localparam int unsigned CTRL_W      = 20;
    localparam int unsigned ALUOP_O     = 0;
    localparam int unsigned IO_O        = 4;
    localparam int unsigned WSRC_O      = 6;
    localparam int unsigned ALUSRC_B    = 8;
    localparam int unsigned BRANCH_B    = 9;
    localparam int unsigned RDIV_B      = 10;
    localparam int unsigned MEMREAD_B   = 11;
    localparam int unsigned HDREAD_B    = 12;
    localparam int unsigned JUMP_B      = 13;
    localparam int unsigned JUMPR_B     = 14;
    localparam int unsigned JLINK_B     = 15;
    localparam int unsigned REGWRITE_B  = 16;
    localparam int unsigned MEMWRITE_B  = 17;
    localparam int unsigned HDWRITE_B   = 18;
    localparam int unsigned INSTWRITE_B = 19;

    // Fields only allowed to be nonzero on the commit strobe
    localparam logic [CTRL_W-1:0] COMMIT_MASK = 20'hFE000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_PASS = 4'd11;
    localparam logic [3:0] ALU_SEQ  = 4'd12;
    localparam logic [3:0] ALU_SNE  = 4'd13;

    localparam logic [1:0] IO_IN    = 2'd1;
    localparam logic [1:0] IO_OUT   = 2'd2;
    localparam logic [1:0] WS_MEM   = 2'd1;
    localparam logic [1:0] WS_IO    = 2'd2;
    localparam logic [1:0] WS_LINK  = 2'd3;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StWait, StCommit, StHalt, StDone, StPreempt
    } state_e;

    typedef enum logic [2:0] {WaitNone, WaitDiv, WaitIn, WaitOut, WaitMem} wait_e;

    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [31:0] op,
                                                      input logic at_commit);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLT, OP_SLL,
            OP_SRL: begin
                c[ALUOP_O +: 4] = op[3:0];
                c[REGWRITE_B]   = 1'b1;
            end
            OP_DIV: begin
                c[ALUOP_O +: 4] = ALU_DIV;
                c[RDIV_B]       = 1'b1;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_LI: begin
                c[ALUOP_O +: 4] = (op == OP_ADDI) ? ALU_ADD : (op == OP_SUBI) ? ALU_SUB : ALU_PASS;
                c[ALUSRC_B]     = 1'b1;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_MOV: begin
                c[ALUOP_O +: 4] = ALU_PASS;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_LW: begin
                c[ALUSRC_B]     = 1'b1;
                c[MEMREAD_B]    = 1'b1;
                c[WSRC_O +: 2]  = WS_MEM;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_SW: begin
                c[ALUSRC_B]     = 1'b1;
                c[MEMWRITE_B]   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c[ALUOP_O +: 4] = (op == OP_BEQ) ? ALU_SEQ : ALU_SNE;
                c[BRANCH_B]     = 1'b1;
            end
            OP_J:  c[JUMP_B]  = 1'b1;
            OP_JR: c[JUMPR_B] = 1'b1;
            OP_JAL: begin
                c[JUMP_B]       = 1'b1;
                c[JLINK_B]      = 1'b1;
                c[WSRC_O +: 2]  = WS_LINK;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_IN: begin
                c[IO_O +: 2]    = IO_IN;
                c[WSRC_O +: 2]  = WS_IO;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_OUT: c[IO_O +: 2] = IO_OUT;
            OP_HDTOREG: begin
                c[HDREAD_B]     = 1'b1;
                c[WSRC_O +: 2]  = WS_MEM;
                c[REGWRITE_B]   = 1'b1;
            end
            OP_REGTOHD: c[HDWRITE_B] = 1'b1;
            OP_HDTOINST: begin
                c[HDREAD_B]     = 1'b1;
                c[INSTWRITE_B]  = 1'b1;
            end
            default: c = '0;
        endcase
        if (!at_commit) c &= ~COMMIT_MASK;
        return c;
    endfunction

    function automatic wait_e wait_sel(input logic [31:0] op);
        case (op)
            OP_DIV:                                              return WaitDiv;
            OP_IN:                                               return WaitIn;
            OP_OUT:                                              return WaitOut;
            OP_LW, OP_SW, OP_HDTOREG, OP_REGTOHD, OP_HDTOINST:   return WaitMem;
            default:                                             return WaitNone;
        endcase
    endfunction

endpackage

// File: rtl/controle_quantum.sv
// Preemption quantum: retired-instruction counter saturating at QUANTUM plus the enable flag.
module controle_quantum #(
    parameter int unsigned QUANTUM_W = 16,
    parameter int unsigned QUANTUM   = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clear,
    input  logic set,
    input  logic unset,
    output logic preempt_en,
    output logic expired
);

    localparam logic [QUANTUM_W-1:0] Limit = QUANTUM_W'(QUANTUM);

    logic                 en_q;
    logic [QUANTUM_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            count_q <= '0;
        end else if (set) begin
            // Re-enabling while already enabled restarts the quantum
            en_q    <= 1'b1;
            count_q <= '0;
        end else if (unset) begin
            en_q    <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && en_q && count_q != Limit) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign preempt_en = en_q;
    assign expired    = en_q && (count_q == Limit);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/WAIT/COMMIT sequencing with handshakes.
// Define CTRL_RETIRE_CNT_EN to add the retired_count output.
module unidade_controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 5,
    parameter int unsigned QUANTUM_W = 16,
    parameter int unsigned QUANTUM   = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_opcode,
    output logic                instr_ready,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                commit,
    input  logic                div_done,
    input  logic                io_in_valid,
    input  logic                io_out_ready,
    input  logic                mem_ready,
    input  logic                resume,
    input  logic                preempt_ack,
`ifdef CTRL_RETIRE_CNT_EN
    output logic [31:0]         retired_count,
`endif
    output logic                preempt_req,
    output logic                preempt_en,
    output logic                halted,
    output logic                finished,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [31:0]         op_ext;
    logic                wait_done;
    logic                expired;
    logic                q_inc, q_clear, q_set, q_unset;

    assign op_ext = 32'(opcode_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFetch;
            opcode_q <= OPCODE_W'(OP_NOP);
        end else begin
            state_q <= state_d;
            if (instr_valid && instr_ready) opcode_q <= instr_opcode;
        end
    end

    always_comb begin
        wait_done = 1'b0;
        case (wait_sel(op_ext))
            WaitDiv: wait_done = div_done;
            WaitIn:  wait_done = io_in_valid;
            WaitOut: wait_done = io_out_ready;
            WaitMem: wait_done = mem_ready;
            default: wait_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ctrl        = '0;
        commit      = 1'b0;
        instr_ready = 1'b0;
        preempt_req = 1'b0;
        q_inc       = 1'b0;
        q_clear     = 1'b0;
        q_set       = 1'b0;
        q_unset     = 1'b0;
        case (state_q)
            StFetch: begin
                if (expired) begin
                    preempt_req = 1'b1;
                    state_d     = StPreempt;
                end else begin
                    instr_ready = 1'b1;
                    if (instr_valid) state_d = StDecode;
                end
            end
            StDecode: begin
                ctrl    = decode_ctrl(op_ext, 1'b0);
                state_d = StExec;
            end
            StExec: begin
                ctrl = decode_ctrl(op_ext, 1'b0);
                if (op_ext == OP_HLT)                 state_d = StHalt;
                else if (op_ext == OP_FINALIZE)       state_d = StDone;
                else if (wait_sel(op_ext) != WaitNone) state_d = StWait;
                else                                  state_d = StCommit;
            end
            StWait: begin
                ctrl = decode_ctrl(op_ext, 1'b0);
                if (wait_done) state_d = StCommit;
            end
            StCommit: begin
                ctrl    = decode_ctrl(op_ext, 1'b1);
                commit  = 1'b1;
                q_inc   = 1'b1;
                q_set   = (op_ext == OP_PREEMPON);
                q_unset = (op_ext == OP_PREEMPOFF);
                state_d = StFetch;
            end
            StHalt: begin
                if (resume) state_d = StFetch;
            end
            StDone: state_d = StDone;
            StPreempt: begin
                preempt_req = 1'b1;
                if (preempt_ack) begin
                    q_clear = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    assign halted   = (state_q == StHalt);
    assign finished = (state_q == StDone);
    assign busy     = !(state_q inside {StFetch, StHalt, StDone});

    controle_quantum #(
        .QUANTUM_W (QUANTUM_W),
        .QUANTUM   (QUANTUM)
    ) u_quantum (
        .clock      (clock),
        .reset_n    (reset_n),
        .inc        (q_inc),
        .clear      (q_clear),
        .set        (q_set),
        .unset      (q_unset),
        .preempt_en (preempt_en),
        .expired    (expired)
    );

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    retired_q <= '0;
        else if (commit) retired_q <= retired_q + 32'd1;
    end

    assign retired_count = retired_q;
`endif

endmodule
